// File: rtl/mul_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mul_div_unit_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - MDU_WIDTH / MDU_ITER : default operand width and iterations per operation
//   - mdu_op_t             : operation encodings driven on the unit's op port
//   - mdu_state_t          : sequencer states (idle, iterate, sign-fix/commit)
// -----------------------------------------------------------------------------
package mul_div_unit_pkg;

    localparam int MDU_WIDTH = 32;
    // One radix-2 step per operand bit.
    localparam int MDU_ITER  = MDU_WIDTH;

    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_addsub.sv
// -----------------------------------------------------------------------------
// mdu_addsub
// Ripple-carry adder/subtractor built from 1-bit full-adder cells.
//   x, y : operands (WIDTH bits)
//   sub  : 0 -> sum = x + y, 1 -> sum = x - y (two's complement)
//   sum  : result (WIDTH bits)
//   cout : carry out; when subtracting, 1 means x >= y (no borrow)
// -----------------------------------------------------------------------------
module mdu_addsub #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] w_y;
    logic [WIDTH:0]   w_c;

    // Subtraction as x + ~y + 1: invert y and inject the +1 as carry-in.
    assign w_y    = y ^ {WIDTH{sub}};
    assign w_c[0] = sub;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            assign sum[i]   = x[i] ^ w_y[i] ^ w_c[i];
            assign w_c[i+1] = (x[i] & w_y[i]) | (w_c[i] & (x[i] ^ w_y[i]));
        end
    endgenerate

    assign cout = w_c[WIDTH];

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Iterative radix-2 multiply/divide unit holding the HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; both run on
// operand magnitudes and apply sign correction in a final FIX cycle.
// MTHI/MTLO write HI/LO directly from a in the accepting cycle.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   start : request pulse, only sampled while idle
//   op    : operation code (see mdu_op_t)
//   a, b  : rs / rt operands
//   flush : abort in-flight operation; blocks a start while idle
//   busy  : operation in progress (CALC or FIX)
//   done  : one-cycle pulse after HI/LO are written by MULT/DIV
//   hi,lo : architectural HI/LO registers
// -----------------------------------------------------------------------------
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_ITER,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] f_neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    mdu_state_t         r_state;
    mdu_state_t         w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    // Multiply: {carry, upper half, multiplier/low half}.
    // Divide:   {unused, remainder, quotient/dividend}.
    logic [2*WIDTH:0]   r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_is_div;
    logic               r_sa;
    logic               r_sb;
    logic               r_div0;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    mdu_op_t            w_op;
    logic               w_accept;
    logic               w_commit;
    logic               w_wr_hi;
    logic               w_wr_lo;
    logic               w_op_div;
    logic               w_op_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_add_x;
    logic [WIDTH:0]     w_add_y;
    logic [WIDTH:0]     w_add_sum;
    logic               w_add_cout;
    logic [2*WIDTH:0]   w_acc_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_op = mdu_op_t'(op);

    // ---------------- Sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        w_wr_hi      = 1'b0;
        w_wr_lo      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !flush) begin
                    case (w_op)
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            w_accept     = 1'b1;
                            w_next_state = S_CALC;
                        end
                        MDU_MTHI: w_wr_hi = 1'b1;
                        MDU_MTLO: w_wr_lo = 1'b1;
                        default:  ;
                    endcase
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == LAST_CNT) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX: begin
                w_next_state = S_IDLE;
                w_commit     = !flush;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- Operand capture ----------------
    assign w_op_div    = (w_op == MDU_DIV) || (w_op == MDU_DIVU);
    assign w_op_signed = (w_op == MDU_MULT) || (w_op == MDU_DIV);
    assign w_sa        = w_op_signed & a[WIDTH-1];
    assign w_sb        = w_op_signed & b[WIDTH-1];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign w_mag_a     = w_sa ? f_neg_w(a) : a;
    assign w_mag_b     = w_sb ? f_neg_w(b) : b;

    // ---------------- Iteration datapath ----------------
    // Divide feeds the left-shifted {rem, quot MSB} as a WIDTH+1-bit trial
    // minuend; multiply adds the multiplicand into the upper half.
    assign w_add_x = r_is_div ? r_acc[2*WIDTH-1:WIDTH-1] : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    assign w_add_y = {1'b0, r_opnd};

    mdu_addsub #(
        .WIDTH (WIDTH + 1)
    ) u_addsub (
        .x    (w_add_x),
        .y    (w_add_y),
        .sub  (r_is_div),
        .sum  (w_add_sum),
        .cout (w_add_cout)
    );

    always_comb begin
        w_acc_next = r_acc;
        if (r_is_div) begin
            if (w_add_cout) begin
                w_acc_next = {1'b0, w_add_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_next = {1'b0, r_acc[2*WIDTH-2:0], 1'b0};
            end
        end else if (r_acc[0]) begin
            w_acc_next = {1'b0, w_add_sum, r_acc[WIDTH-1:1]};
        end else begin
            w_acc_next = {1'b0, r_acc[2*WIDTH:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_div <= w_op_div;
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_div0   <= w_op_div && (b == {WIDTH{1'b0}});
            r_opnd   <= w_op_div ? w_mag_b : w_mag_a;
            r_acc    <= {1'b0, {WIDTH{1'b0}}, (w_op_div ? w_mag_a : w_mag_b)};
        end else if (r_state == S_CALC) begin
            r_acc    <= w_acc_next;
        end
    end

    // ---------------- Sign fix / commit ----------------
    assign w_prod_fix = (r_sa ^ r_sb) ? f_neg_2w(r_acc[2*WIDTH-1:0]) : r_acc[2*WIDTH-1:0];
    assign w_quot_fix = (r_sa ^ r_sb) ? f_neg_w(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_sa ? f_neg_w(r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];

    // Divide by zero leaves rem = dividend naturally; only LO is forced.
    assign w_res_hi = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_res_lo = r_is_div ? (r_div0 ? {WIDTH{1'b1}} : w_quot_fix)
                               : w_prod_fix[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_done <= 1'b0;
            r_hi   <= {WIDTH{1'b0}};
            r_lo   <= {WIDTH{1'b0}};
        end else begin
            r_done <= w_commit;
            if (w_accept) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_commit) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else begin
                if (w_wr_hi) begin
                    r_hi <= a;
                end
                if (w_wr_lo) begin
                    r_lo <= a;
                end
            end
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Scoreboard bench for mul_div_unit: stimulus pushes expected {hi,lo} from a
// plain-arithmetic reference model; a monitor pops on every done pulse.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           checks = 0;
    int           errors = 0;
    logic [63:0]  exp_q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int           bcnt = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: returns {hi, lo} from ordinary 64-bit / 32-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint      p;
        int          q;
        int          rm;
        logic [63:0] r;
        r = {m_hi, m_lo};
        case (o)
            3'd1: begin
                p = longint'($signed(x)) * longint'($signed(y));
                r = p;
            end
            3'd2: r = {32'b0, x} * {32'b0, y};
            3'd3: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    q  = $signed(x) / $signed(y);
                    rm = $signed(x) % $signed(y);
                    r  = {rm, q};
                end
            end
            3'd4: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else r = {x % y, x / y};
            end
            default: ;
        endcase
        return r;
    endfunction

    // Monitor: compare on every done, and check busy length of each completed op.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            bcnt = 0;
        end else begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no pending result", hi, lo);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_hi", 64'(hi), 64'(e[63:32]));
                    chk("result_lo", 64'(lo), 64'(e[31:0]));
                    m_hi = e[63:32];
                    m_lo = e[31:0];
                end
            end
            if (busy) begin
                bcnt++;
            end else begin
                if (bcnt != 0 && done) chk("busy_cycles", 64'(bcnt), 64'd33);
                bcnt = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit push);
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        if (push && o >= 3'd1 && o <= 3'd4) exp_q.push_back(model(o, x, y));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_results(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  dir_op [5] = '{3'd2, 3'd1, 3'd3, 3'd4, 3'd3};
        logic [31:0] dir_a  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
        logic [31:0] dir_b  [5] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [2:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        int          n;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi",   64'(hi),   64'd0);
        chk("reset_lo",   64'(lo),   64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        rst = 1'b0;

        // Directed arithmetic cases including overflow and divide by zero.
        for (int i = 0; i < 5; i++) begin
            issue(dir_op[i], dir_a[i], dir_b[i], 1'b1);
            #1 chk("busy_after_start", 64'(busy), 64'd1);
            wait_results("directed_timeout");
        end

        // MTHI then MTLO on consecutive edges.
        issue(3'd5, 32'h1234_5678, 32'h0, 1'b0);
        chk("mthi_hi",   64'(hi),   64'h1234_5678);
        chk("mthi_busy", 64'(busy), 64'd0);
        issue(3'd6, 32'h9ABC_DEF0, 32'h0, 1'b0);
        chk("mtlo_lo",   64'(lo),   64'h9ABC_DEF0);
        chk("mtlo_hi",   64'(hi),   64'h1234_5678);
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mtlo_done", 64'(done), 64'd0);
        m_hi = 32'h1234_5678;
        m_lo = 32'h9ABC_DEF0;

        // flush while idle blocks a simultaneous start.
        @(negedge clk);
        op = 3'd5; a = 32'hDEAD_BEEF; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        chk("idle_flush_blocks_hi", 64'(hi), 64'(m_hi));

        // A second start while busy is ignored.
        issue(3'd2, 32'd3, 32'd5, 1'b1);
        repeat (5) @(negedge clk);
        issue(3'd4, 32'd1, 32'd1, 1'b0);
        wait_results("ignored_start_timeout");
        repeat (40) @(negedge clk);
        chk("ignored_start_hi", 64'(hi), 64'd0);
        chk("ignored_start_lo", 64'(lo), 64'd15);

        // Flush mid-CALC.
        issue(3'd4, 32'd1000, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        chk("flush_hi", 64'(hi), 64'(m_hi));
        chk("flush_lo", 64'(lo), 64'(m_lo));

        // Reset mid-CALC.
        issue(3'd1, 32'd123, 32'd456, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_mid_hi",   64'(hi),   64'd0);
        chk("rst_mid_lo",   64'(lo),   64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        m_hi = '0;
        m_lo = '0;
        repeat (40) @(negedge clk);

        // Back-to-back: second start issued in the done cycle.
        issue(3'd2, 32'd3, 32'd5, 1'b1);
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", 64'(done), 64'd1);
        op = 3'd4; a = 32'd17; b = 32'd5; start = 1'b1;
        exp_q.push_back(model(3'd4, 32'd17, 32'd5));
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b_second_busy", 64'(busy), 64'd1);
        wait_results("b2b_timeout");
        chk("b2b_hi", 64'(hi), 64'd2);
        chk("b2b_lo", 64'(lo), 64'd3);

        // Randomized operations.
        for (int i = 0; i < 150; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: ry = 32'($urandom_range(1, 15));
                2: ry = 32'hFFFF_FFFF;
                default: ry = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) rx = 32'h8000_0000;
            if (ro >= 3'd1 && ro <= 3'd4) begin
                issue(ro, rx, ry, 1'b1);
                wait_results("random_timeout");
            end else begin
                issue(ro, rx, ry, 1'b0);
                if (ro == 3'd5) m_hi = rx;
                if (ro == 3'd6) m_lo = rx;
                chk("random_move_hi",   64'(hi),   64'(m_hi));
                chk("random_move_lo",   64'(lo),   64'(m_lo));
                chk("random_move_busy", 64'(busy), 64'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
